// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the FSM state encoding, the NOP encoding and the default PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_e;

  localparam int NOP_INSTR       = 0;
  localparam int PC_STEP_DEFAULT = 1;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that parks a fetched instruction and its PC
// while decode is backpressuring the IF/ID register.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int BUS_WIDTH   = 16,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   drop,
  input  logic [BUS_WIDTH-1:0]   load_pc,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  output logic                   skid_valid,
  output logic [BUS_WIDTH-1:0]   skid_pc,
  output logic [INSTR_WIDTH-1:0] skid_instr
);

  logic                   valid_reg;
  logic [BUS_WIDTH-1:0]   pc_reg;
  logic [INSTR_WIDTH-1:0] instr_reg;

  // Load wins over drop: a fresh capture always replaces a stale entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= INSTR_WIDTH'(NOP_INSTR);
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end else if (drop) begin
      valid_reg <= 1'b0;
    end
  end

  assign skid_valid = valid_reg;
  assign skid_pc    = pc_reg;
  assign skid_instr = instr_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: steers the PC register, runs the imem
// request handshake, and fills the IF/ID register with redirect flush.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int BUS_WIDTH   = 16,
  parameter int INSTR_WIDTH = 16,
  parameter int PC_STEP     = PC_STEP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BUS_WIDTH-1:0]   pc,
  output logic [BUS_WIDTH-1:0]   pc_next,
  output logic                   stall,
  output logic                   imem_req,
  output logic [BUS_WIDTH-1:0]   imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect,
  input  logic [BUS_WIDTH-1:0]   redirect_target,
  input  logic                   id_stall,
  output logic                   ifid_valid,
  output logic [BUS_WIDTH-1:0]   ifid_pc,
  output logic [INSTR_WIDTH-1:0] ifid_instr
);

  fetch_state_e           state_reg, state_next;
  logic [BUS_WIDTH-1:0]   pend_target_reg, pend_target_next;
  logic                   ifid_valid_reg;
  logic [BUS_WIDTH-1:0]   ifid_pc_reg;
  logic [INSTR_WIDTH-1:0] ifid_instr_reg;

  logic                   can_accept;
  logic                   cap_mem, cap_skid;
  logic                   skid_load, skid_drop, skid_valid;
  logic [BUS_WIDTH-1:0]   skid_pc, pc_inc;
  logic [INSTR_WIDTH-1:0] skid_instr;

  assign can_accept = !ifid_valid_reg || !id_stall;
  assign pc_inc     = pc + BUS_WIDTH'(PC_STEP);
  assign imem_addr  = pc;

  fetch_skid #(
    .BUS_WIDTH  (BUS_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .drop      (skid_drop),
    .load_pc   (pc),
    .load_instr(imem_rdata),
    .skid_valid(skid_valid),
    .skid_pc   (skid_pc),
    .skid_instr(skid_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      pend_target_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pend_target_reg <= pend_target_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pend_target_next = pend_target_reg;
    stall            = 1'b1;
    pc_next          = pc;
    imem_req         = 1'b0;
    cap_mem          = 1'b0;
    cap_skid         = 1'b0;
    skid_load        = 1'b0;
    skid_drop        = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_FETCH;
          if (redirect) begin
            stall   = 1'b0;
            pc_next = redirect_target;
          end
        end
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            if (redirect) begin
              stall   = 1'b0;
              pc_next = redirect_target;
            end else if (can_accept) begin
              cap_mem = 1'b1;
              stall   = 1'b0;
              pc_next = pc_inc;
            end else begin
              skid_load  = 1'b1;
              state_next = ST_HOLD;
            end
          end else if (redirect) begin
            // Request is in flight and cannot be abandoned; remember where to go.
            pend_target_next = redirect_target;
            state_next       = ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            skid_drop  = 1'b1;
            stall      = 1'b0;
            pc_next    = redirect_target;
            state_next = ST_FETCH;
          end else if (can_accept && skid_valid) begin
            cap_skid   = 1'b1;
            skid_drop  = 1'b1;
            stall      = 1'b0;
            pc_next    = pc_inc;
            state_next = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          imem_req = 1'b1;
          if (redirect) pend_target_next = redirect_target;
          if (imem_ready) begin
            stall      = 1'b0;
            pc_next    = redirect ? redirect_target : pend_target_reg;
            state_next = ST_FETCH;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Flush beats capture so a taken branch never lets a wrong-path instruction through.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid_reg <= 1'b0;
      ifid_pc_reg    <= '0;
      ifid_instr_reg <= INSTR_WIDTH'(NOP_INSTR);
    end else if (redirect) begin
      ifid_valid_reg <= 1'b0;
    end else if (cap_mem) begin
      ifid_valid_reg <= 1'b1;
      ifid_pc_reg    <= pc;
      ifid_instr_reg <= imem_rdata;
    end else if (cap_skid) begin
      ifid_valid_reg <= 1'b1;
      ifid_pc_reg    <= skid_pc;
      ifid_instr_reg <= skid_instr;
    end else if (!id_stall) begin
      ifid_valid_reg <= 1'b0;
    end
  end

  assign ifid_valid = ifid_valid_reg;
  assign ifid_pc    = ifid_pc_reg;
  assign ifid_instr = ifid_instr_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the PC register and a simple imem,
// then walks reset, streaming, wait states, backpressure, redirects and wrap.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        id_stall;
  logic        ifid_valid;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_instr;

  int total = 0;
  int bad   = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_next        (pc_next),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .id_stall       (id_stall),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr)
  );

  always #5 clk = ~clk;

  // PC register driven by the controller's pc_next/stall.
  always @(posedge clk) begin
    if (rst) pc <= 16'h0000;
    else if (!stall) pc <= pc_next;
  end

  assign imem_rdata = 16'h1000 + imem_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    imem_ready      = 1'b1;
    redirect        = 1'b0;
    redirect_target = 16'h0000;
    id_stall        = 1'b0;

    // Reset
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_stall", stall, 1);
      check("rst_req", imem_req, 0);
      check("rst_valid", ifid_valid, 0);
      check("rst_ifid_pc", ifid_pc, 16'h0000);
      check("rst_pc_next", pc_next, 16'h0000);
    end
    rst = 1'b0;
    #1;
    check("idle_req", imem_req, 0);
    check("idle_stall", stall, 1);
    step();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 16'h0000);
    check("first_stall", stall, 0);

    // Streaming
    for (int k = 0; k < 4; k++) begin
      step();
      check("stream_valid", ifid_valid, 1);
      check("stream_pc", ifid_pc, 16'(k));
      check("stream_instr", ifid_instr, 16'h1000 + 16'(k));
      check("stream_stall", stall, 0);
    end
    check("stream_end_pc", pc, 16'h0004);

    // Wait states at 0x0004
    imem_ready = 1'b0;
    #1;
    check("wait_stall0", stall, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_addr", imem_addr, 16'h0004);
      check("wait_req", imem_req, 1);
      check("wait_stall", stall, 1);
      check("wait_valid", ifid_valid, 0);
    end
    imem_ready = 1'b1;
    step();
    check("wait_done_pc", ifid_pc, 16'h0004);
    check("wait_done_valid", ifid_valid, 1);
    check("wait_done_instr", ifid_instr, 16'h1004);
    check("wait_done_pcreg", pc, 16'h0005);

    // Backpressure while 0x0005 returns
    id_stall = 1'b1;
    #1;
    check("bp_stall", stall, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("hold_req", imem_req, 0);
      check("hold_ifid_pc", ifid_pc, 16'h0004);
      check("hold_valid", ifid_valid, 1);
      check("hold_pc", pc, 16'h0005);
    end
    id_stall = 1'b0;
    #1;
    check("release_stall", stall, 0);
    check("release_pc_next", pc_next, 16'h0006);
    step();
    check("release_ifid_pc", ifid_pc, 16'h0005);
    check("release_instr", ifid_instr, 16'h1005);
    check("release_pc", pc, 16'h0006);
    step();
    step();
    check("pre_redir_pc", pc, 16'h0008);

    // Redirect during wait, then a second redirect in DRAIN
    imem_ready      = 1'b0;
    redirect        = 1'b1;
    redirect_target = 16'h0040;
    #1;
    check("redir_wait_stall", stall, 1);
    step();
    redirect = 1'b0;
    check("drain_valid", ifid_valid, 0);
    check("drain_req", imem_req, 1);
    check("drain_addr", imem_addr, 16'h0008);
    redirect        = 1'b1;
    redirect_target = 16'h0050;
    step();
    redirect = 1'b0;
    check("drain2_addr", imem_addr, 16'h0008);
    check("drain2_stall", stall, 1);
    step();
    imem_ready = 1'b1;
    #1;
    check("drain_exit_pc_next", pc_next, 16'h0050);
    check("drain_exit_stall", stall, 0);
    step();
    check("after_drain_pc", pc, 16'h0050);
    check("after_drain_valid", ifid_valid, 0);
    step();
    check("target_ifid_pc", ifid_pc, 16'h0050);
    check("target_instr", ifid_instr, 16'h1050);
    check("target_valid", ifid_valid, 1);

    // Redirect with ready in FETCH, landing near the wrap point
    redirect        = 1'b1;
    redirect_target = 16'hFFFE;
    step();
    redirect = 1'b0;
    check("redir_flush_valid", ifid_valid, 0);
    check("redir_pc", pc, 16'hFFFE);
    step();
    check("wrap_ifid_fffe", ifid_pc, 16'hFFFE);
    check("wrap_pc_ffff", pc, 16'hFFFF);
    check("wrap_pc_next", pc_next, 16'h0000);
    check("wrap_stall", stall, 0);
    step();
    check("wrap_ifid_ffff", ifid_pc, 16'hFFFF);
    check("wrap_addr", imem_addr, 16'h0000);
    step();
    check("wrap_ifid_zero", ifid_pc, 16'h0000);
    check("wrap_instr", ifid_instr, 16'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
